// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package im_pkg;

    // Default instruction memory depth in 32-bit words.
    localparam int unsigned NMEM_DEFAULT = 128;

    // Byte-lane order within a word: lane 0 is the first byte received and
    // lands in bits 31:24 (big-endian); lane 3 completes the word.
    localparam logic [1:0] LANE_FIRST = 2'd0;
    localparam logic [1:0] LANE_LAST  = 2'd3;

    // Loader states.
    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StCsum,
        StRun,
        StErr
    } state_e;

endpackage

// File: rtl/im_word_pack.sv
// Packs a stream of bytes into big-endian 32-bit words. The first three lanes
// are held in a shift register; the fourth byte completes the word directly,
// so o_word/o_word_valid are valid in the cycle that byte is accepted.
module im_word_pack
    import im_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;

    assign o_word_valid = i_byte_en && (r_idx == LANE_LAST);
    assign o_word       = {r_shift, i_byte};

    // Shift accepted bytes in MSB-first; the lane index wraps after lane 3.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_idx   <= LANE_FIRST;
            r_shift <= '0;
        end else if (i_byte_en) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
        end
    end

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction memory loader: receives a COUNT/data/CSUM byte frame,
// writes packed words sequentially into instruction memory, verifies the XOR
// checksum, and holds the CPU stalled until a good frame has been loaded.
module im_loader
    import im_pkg::*;
#(
    parameter int unsigned NMEM = NMEM_DEFAULT,
    parameter int unsigned AW   = 7
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start_load,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte_data,
    output logic          o_byte_ready,
    input  logic [31:0]   i_fetch_addr,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_waddr,
    output logic [31:0]   o_mem_wdata,
    output logic          o_cpu_run,
    output logic          o_load_done,
    output logic          o_load_err,
    output logic [AW:0]   o_words_loaded
);

    state_e        r_state;
    state_e        w_state_next;
    logic          r_byte_ready;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_waddr;
    logic [31:0]   r_mem_wdata;
    logic          r_load_done;
    logic          r_load_err;
    logic [AW:0]   r_words_loaded;
    logic [7:0]    r_count_m1;
    logic [7:0]    r_xor;

    logic          w_accept;
    logic          w_enter_hdr;
    logic          w_count_bad;
    logic          w_last_word;
    logic          w_csum_ok;
    logic          w_word_valid;
    logic [31:0]   w_word;
    logic          w_unused_fetch;

    assign w_accept    = i_byte_valid && r_byte_ready;
    assign w_enter_hdr = i_start_load &&
                         ((r_state == StIdle) || (r_state == StRun) || (r_state == StErr));
    // COUNT holds n; the frame carries n+1 words, which must fit in memory.
    assign w_count_bad = ({1'b0, i_byte_data} + 9'd1) > 9'(NMEM);
    // words_loaded is the index of the word being completed, so it equals n
    // on the final word.
    assign w_last_word = ({1'b0, r_count_m1} == 9'(r_words_loaded));
    assign w_csum_ok   = (i_byte_data == r_xor);

    im_word_pack u_word_pack (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_enter_hdr),
        .i_byte_en    (w_accept && (r_state == StData)),
        .i_byte       (i_byte_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start_load is only honoured outside a frame.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_enter_hdr) w_state_next = StHdr;
            StHdr:   if (w_accept) w_state_next = w_count_bad ? StErr : StData;
            StData:  if (w_word_valid && w_last_word) w_state_next = StCsum;
            StCsum:  if (w_accept) w_state_next = w_csum_ok ? StRun : StErr;
            StRun:   if (w_enter_hdr) w_state_next = StHdr;
            StErr:   if (w_enter_hdr) w_state_next = StHdr;
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: ready flag, word writes, counters, checksum and status flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_byte_ready   <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_waddr    <= '0;
            r_mem_wdata    <= '0;
            r_load_done    <= 1'b0;
            r_load_err     <= 1'b0;
            r_words_loaded <= '0;
            r_count_m1     <= '0;
            r_xor          <= '0;
        end else begin
            r_byte_ready <= (w_state_next == StHdr) || (w_state_next == StData) ||
                            (w_state_next == StCsum);
            r_mem_we     <= 1'b0;

            if (w_enter_hdr) begin
                r_words_loaded <= '0;
                r_load_done    <= 1'b0;
                r_load_err     <= 1'b0;
            end

            if (w_accept && (r_state == StHdr)) begin
                r_count_m1 <= i_byte_data;
                r_xor      <= i_byte_data;
                if (w_count_bad) begin
                    r_load_err <= 1'b1;
                end
            end

            if (w_accept && (r_state == StData)) begin
                r_xor <= r_xor ^ i_byte_data;
            end

            // The write address is the running word count.
            if (w_word_valid) begin
                r_mem_we       <= 1'b1;
                r_mem_waddr    <= r_words_loaded[AW-1:0];
                r_mem_wdata    <= w_word;
                r_words_loaded <= r_words_loaded + 1'b1;
            end

            if (w_accept && (r_state == StCsum)) begin
                if (w_csum_ok) begin
                    r_load_done <= 1'b1;
                end else begin
                    r_load_err <= 1'b1;
                end
            end
        end
    end

    assign w_unused_fetch = ^{i_fetch_addr[31:AW+2], i_fetch_addr[1:0]};

    assign o_byte_ready   = r_byte_ready;
    assign o_mem_we       = r_mem_we;
    assign o_mem_waddr    = r_mem_waddr;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_cpu_run      = (r_state == StRun);
    assign o_load_done    = r_load_done;
    assign o_load_err     = r_load_err;
    assign o_words_loaded = r_words_loaded;
    // While loading, the read port follows the write address.
    assign o_rd_addr      = o_cpu_run ? i_fetch_addr[AW+1:2] : r_mem_waddr;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: a frame-level model predicts every
// output each cycle, and directed scenarios pin key values by hand.
module tb_im_loader;

    localparam int unsigned NMEM = 128;
    localparam int unsigned AW   = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_load = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic [31:0]   fetch_addr = 32'h0;
    logic          o_byte_ready;
    logic [AW-1:0] o_rd_addr;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_waddr;
    logic [31:0]   o_mem_wdata;
    logic          o_cpu_run;
    logic          o_load_done;
    logic          o_load_err;
    logic [AW:0]   o_words_loaded;

    always #5 clk = ~clk;

    im_loader #(.NMEM(NMEM), .AW(AW)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start_load   (start_load),
        .i_byte_valid   (byte_valid),
        .i_byte_data    (byte_data),
        .o_byte_ready   (o_byte_ready),
        .i_fetch_addr   (fetch_addr),
        .o_rd_addr      (o_rd_addr),
        .o_mem_we       (o_mem_we),
        .o_mem_waddr    (o_mem_waddr),
        .o_mem_wdata    (o_mem_wdata),
        .o_cpu_run      (o_cpu_run),
        .o_load_done    (o_load_done),
        .o_load_err     (o_load_err),
        .o_words_loaded (o_words_loaded)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned edge_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Frame-level model: tracks bytes accepted in the current frame.
    bit            m_busy = 0, m_run = 0, m_done = 0, m_err = 0, m_we = 0;
    int            m_nb = 0, m_words = 0, m_wl = 0;
    logic [7:0]    m_xor = 8'h00;
    logic [31:0]   m_word = 32'h0, m_wdata = 32'h0;
    logic [AW-1:0] m_waddr = '0;

    // Observed memory writes, in order.
    logic [AW-1:0] wl_addr[$];
    logic [31:0]   wl_data[$];

    always @(posedge clk) begin
        edge_cnt++;
        if (o_mem_we === 1'b1) begin
            wl_addr.push_back(o_mem_waddr);
            wl_data.push_back(o_mem_wdata);
        end
        m_we = 1'b0;
        if (reset) begin
            m_busy = 0; m_run = 0; m_done = 0; m_err = 0;
            m_wl = 0; m_waddr = '0; m_wdata = 32'h0; m_nb = 0;
        end else if (m_busy) begin
            if (byte_valid) begin
                if (m_nb == 0) begin
                    if (int'(byte_data) + 1 > int'(NMEM)) begin
                        m_busy = 0; m_err = 1;
                    end else begin
                        m_words = int'(byte_data) + 1; m_xor = byte_data; m_nb = 1;
                    end
                end else if (m_nb <= 4 * m_words) begin
                    m_xor  = m_xor ^ byte_data;
                    m_word = {m_word[23:0], byte_data};
                    if (m_nb % 4 == 0) begin
                        m_we = 1; m_waddr = AW'(m_nb / 4 - 1); m_wdata = m_word; m_wl = m_nb / 4;
                    end
                    m_nb++;
                end else begin
                    m_busy = 0;
                    if (byte_data == m_xor) begin m_run = 1; m_done = 1; end
                    else m_err = 1;
                end
            end
        end else if (start_load) begin
            m_busy = 1; m_nb = 0; m_run = 0; m_done = 0; m_err = 0; m_wl = 0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("byte_ready", 32'(o_byte_ready), 32'(m_busy));
            chk("cpu_run", 32'(o_cpu_run), 32'(m_run));
            chk("load_done", 32'(o_load_done), 32'(m_done));
            chk("load_err", 32'(o_load_err), 32'(m_err));
            chk("mem_we", 32'(o_mem_we), 32'(m_we));
            chk("mem_waddr", 32'(o_mem_waddr), 32'(m_waddr));
            chk("mem_wdata", o_mem_wdata, m_wdata);
            chk("words_loaded", 32'(o_words_loaded), 32'(m_wl));
            chk("rd_addr", 32'(o_rd_addr), m_run ? 32'(fetch_addr[AW+1:2]) : 32'(m_waddr));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic rs, input logic sl, input logic v, input logic [7:0] d);
        @(negedge clk);
        reset = rs; start_load = sl; byte_valid = v; byte_data = d;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic start(output int unsigned s);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        s = edge_cnt + 1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit gaps);
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) idle();
        end
        cyc(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic send_frame(input logic [7:0] f [10]);
        for (int i = 0; i < 10; i++) send_byte(f[i], 1'b0);
    endtask

    // Idles until cpu_run rises or the budget expires; returns edges since s.
    task automatic wait_run(input int unsigned s, output int unsigned lat);
        bit found;
        found = 0;
        lat = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            idle();
            if (o_cpu_run === 1'b1) begin
                found = 1;
                lat = edge_cnt - s;
            end
        end
    endtask

    logic [7:0]  f1 [10] = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78,
                             8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01};
    logic [7:0]  f_bad [10];
    logic [31:0] big [128];
    logic [7:0]  csum;
    int unsigned s_edge, lat;
    int          base;

    initial begin
        // Reset, then idle with a stray byte offered.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        idle();
        chk("rst_byte_ready", 32'(o_byte_ready), 32'd0);
        chk("rst_cpu_run", 32'(o_cpu_run), 32'd0);
        chk("rst_words_loaded", 32'(o_words_loaded), 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'hAA);
        cyc(1'b0, 1'b0, 1'b1, 8'hAA);
        idle();
        idle();
        chk("idle_no_write", 32'(wl_addr.size()), 32'd0);
        chk("idle_byte_ready", 32'(o_byte_ready), 32'd0);

        // Two-word frame with a good checksum, no bubbles.
        start(s_edge);
        send_frame(f1);
        wait_run(s_edge, lat);
        chk("f1_run_latency", lat, 32'd10);
        chk("f1_write_count", 32'(wl_addr.size()), 32'd2);
        chk("f1_w0_addr", 32'(wl_addr[0]), 32'd0);
        chk("f1_w0_data", wl_data[0], 32'h12345678);
        chk("f1_w1_addr", 32'(wl_addr[1]), 32'd1);
        chk("f1_w1_data", wl_data[1], 32'h9ABCDEF0);
        chk("f1_load_done", 32'(o_load_done), 32'd1);
        chk("f1_words_loaded", 32'(o_words_loaded), 32'd2);
        fetch_addr = 32'h4;
        #1;
        chk("f1_rd_addr_4", 32'(o_rd_addr), 32'd1);
        fetch_addr = 32'h1FC;
        #1;
        chk("f1_rd_addr_1fc", 32'(o_rd_addr), 32'd127);

        // Same frame, bad checksum.
        f_bad = f1;
        f_bad[9] = 8'h00;
        base = wl_addr.size();
        start(s_edge);
        send_frame(f_bad);
        idle();
        idle();
        chk("bad_writes", 32'(wl_addr.size() - base), 32'd2);
        chk("bad_load_err", 32'(o_load_err), 32'd1);
        chk("bad_cpu_run", 32'(o_cpu_run), 32'd0);
        start(s_edge);
        idle();
        chk("restart_load_err", 32'(o_load_err), 32'd0);
        chk("restart_byte_ready", 32'(o_byte_ready), 32'd1);

        // Oversized COUNT: immediate error, no writes.
        base = wl_addr.size();
        send_byte(8'h80, 1'b0);
        idle();
        chk("ovf_load_err", 32'(o_load_err), 32'd1);
        chk("ovf_byte_ready", 32'(o_byte_ready), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'h11);
        idle();
        chk("ovf_no_write", 32'(wl_addr.size() - base), 32'd0);

        // start_load coinciding with reset is dropped.
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        idle();
        chk("rst_start_byte_ready", 32'(o_byte_ready), 32'd0);
        idle();
        chk("rst_start_still_idle", 32'(o_byte_ready), 32'd0);

        // Full-depth frame with random byte gaps.
        base = wl_addr.size();
        csum = 8'h7F;
        for (int i = 0; i < 128; i++) begin
            big[i] = $urandom;
            csum = csum ^ big[i][31:24] ^ big[i][23:16] ^ big[i][15:8] ^ big[i][7:0];
        end
        start(s_edge);
        send_byte(8'h7F, 1'b1);
        for (int i = 0; i < 128; i++) begin
            send_byte(big[i][31:24], 1'b1);
            send_byte(big[i][23:16], 1'b1);
            send_byte(big[i][15:8], 1'b1);
            send_byte(big[i][7:0], 1'b1);
        end
        send_byte(csum, 1'b1);
        wait_run(s_edge, lat);
        chk("big_cpu_run", 32'(o_cpu_run), 32'd1);
        chk("big_write_count", 32'(wl_addr.size() - base), 32'd128);
        for (int i = 0; i < 128 && base + i < wl_addr.size(); i++) begin
            chk("big_addr", 32'(wl_addr[base + i]), 32'(i));
            chk("big_data", wl_data[base + i], big[i]);
        end
        chk("big_words_loaded", 32'(o_words_loaded), 32'd128);
        chk("big_final_waddr", 32'(o_mem_waddr), 32'h7F);
        chk("big_load_done", 32'(o_load_done), 32'd1);

        // Reset after six data bytes, then a clean reload.
        base = wl_addr.size();
        start(s_edge);
        for (int i = 0; i < 7; i++) send_byte(f1[i], 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        idle();
        chk("mid_rst_byte_ready", 32'(o_byte_ready), 32'd0);
        chk("mid_rst_cpu_run", 32'(o_cpu_run), 32'd0);
        chk("mid_rst_words_loaded", 32'(o_words_loaded), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'h55);
        idle();
        idle();
        chk("mid_rst_writes", 32'(wl_addr.size() - base), 32'd1);
        chk("mid_rst_cpu_run_held", 32'(o_cpu_run), 32'd0);
        base = wl_addr.size();
        start(s_edge);
        send_frame(f1);
        wait_run(s_edge, lat);
        chk("reload_latency", lat, 32'd10);
        chk("reload_writes", 32'(wl_addr.size() - base), 32'd2);
        if (wl_addr.size() >= base + 2) begin
            chk("reload_w0_data", wl_data[base], 32'h12345678);
            chk("reload_w1_data", wl_data[base + 1], 32'h9ABCDEF0);
        end
        chk("reload_load_done", 32'(o_load_done), 32'd1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
